// File: rtl/mips_muldiv_unit.sv
// Multicycle multiply/divide unit with HI/LO registers for the multicycle MIPS core.
// One shift-add or restoring-subtract iteration per clock on operand magnitudes, sign fixup at the end.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DZ   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_b_q, opnd_b_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // Operand decode and magnitudes, used only on the start edge.
  logic               signed_op;
  logic               div_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_mag     = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign b_mag     = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Multiply step: multiplier shifts out of acc_lo while the partial product shifts in from the top.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;

  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_b_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring divide step: acc_hi is the partial remainder, acc_lo turns from dividend into quotient.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_b_q};
  assign div_hi    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_lo    = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  // Handshake: start is a request taken only when busy=0 (the IDLE state); while busy=1 start and
  // the operands are ignored, done/div_by_zero pulse for one cycle, abort cancels any busy state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_b_d  = opnd_b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_hi_d  = '0;
              is_div_d  = div_op;
              neg_res_d = signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem_d = signed_op && div_op && rs_val[WIDTH-1];
              if (div_op) begin
                acc_lo_d = a_mag;
                opnd_b_d = b_mag;
              end else begin
                acc_lo_d = b_mag;
                opnd_b_d = a_mag;
              end
              if (div_op && (rt_val == '0)) begin
                state_d = S_DZ;
              end else begin
                state_d = S_RUN;
                cnt_d   = CNT_W'(WIDTH);
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = is_div_q ? div_hi : mul_hi;
          acc_lo_d = is_div_q ? div_lo : mul_lo;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      S_DZ: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_b_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_b_q  <= opnd_b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic reference model checked every cycle, directed
// literal cases, and a randomized phase; a small WIDTH=8 instance covers the narrow case.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         Clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         abort;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   state_out;

  always #5 Clk = ~Clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .state_out(state_out)
  );

  logic       s8_start;
  logic [2:0] s8_op;
  logic [7:0] s8_rs;
  logic [7:0] s8_rt;
  logic       s8_abort;
  logic       s8_busy;
  logic       s8_done;
  logic       s8_dz;
  logic [7:0] s8_hi;
  logic [7:0] s8_lo;
  logic [1:0] s8_state;

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .reset(reset), .start(s8_start), .op(s8_op), .rs_val(s8_rs), .rt_val(s8_rt),
    .abort(s8_abort), .busy(s8_busy), .done(s8_done), .div_by_zero(s8_dz), .hi(s8_hi),
    .lo(s8_lo), .state_out(s8_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic         dz;
  } res_t;

  function automatic res_t compute(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t         r;
    longint       sa;
    longint       sb;
    longint       q;
    longint       rem;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); r.h = p[63:32]; r.l = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; r.h = p[63:32]; r.l = p[31:0]; end
      3'd2: begin
        if (b == '0) r.dz = 1'b1;
        else begin
          q = sa / sb; rem = sa % sb;
          p = 64'(q); r.l = p[31:0];
          p = 64'(rem); r.h = p[31:0];
        end
      end
      default: begin
        if (b == '0) r.dz = 1'b1;
        else begin r.l = a / b; r.h = a % b; end
      end
    endcase
    return r;
  endfunction

  bit           m_pend = 1'b0;
  int           m_rem  = 0;
  res_t         m_res  = '0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  bit           m_done = 1'b0;
  bit           m_dzf  = 1'b0;

  // Model: a pending result matures after a fixed number of edges unless aborted.
  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_pend <= 1'b0;
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_dzf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dzf  <= 1'b0;
      if (m_pend) begin
        if (abort) m_pend <= 1'b0;
        else if (m_rem == 1) begin
          m_pend <= 1'b0;
          m_done <= 1'b1;
          if (m_res.dz) m_dzf <= 1'b1;
          else begin m_hi <= m_res.h; m_lo <= m_res.l; end
        end else m_rem <= m_rem - 1;
      end else if (start) begin
        if (op == 3'd4) m_hi <= rs_val;
        else if (op == 3'd5) m_lo <= rs_val;
        else if (op < 3'd4) begin
          m_res  <= compute(op, rs_val, rt_val);
          m_pend <= 1'b1;
          m_rem  <= (op[1] && rt_val == '0) ? 1 : W + 1;
        end
      end
    end
  end

  function automatic logic [1:0] exp_state();
    if (!m_pend) return 2'd0;
    if (m_res.dz) return 2'd3;
    if (m_rem == 1) return 2'd2;
    return 2'd1;
  endfunction

  always @(negedge Clk) begin
    check("busy", 64'(busy), 64'(m_pend));
    check("done", 64'(done), 64'(m_done));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dzf));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("state_out", 64'(state_out), 64'(exp_state()));
  end

  // ---------------- driver tasks (called right after a negedge) ----------------
  task automatic mt(input logic [2:0] o, input logic [W-1:0] v);
    start = 1'b1; op = o; rs_val = v;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int elat, input logic edz);
    int k;
    bit got;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge Clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    k = 0; got = 1'b0;
    while (!got && k < 60) begin
      if (done) got = 1'b1;
      else begin @(negedge Clk); k++; end
    end
    check({name, "_latency"}, 64'(got ? k : -1), 64'(elat));
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    check({name, "_dz"}, 64'(div_by_zero), 64'(edz));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int k;
    reset = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; abort = 1'b0;
    s8_start = 1'b0; s8_op = '0; s8_rs = '0; s8_rt = '0; s8_abort = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    reset = 1'b1;
    @(negedge Clk);

    run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
    run_op("multu_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("mult_m1m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, 1'b0);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 33, 1'b0);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);

    mt(3'd4, 32'hAAAA_0000);
    mt(3'd5, 32'h0000_5555);
    run_op("divu_dz", 3'd3, 32'd7, 32'd0, 32'hAAAA_0000, 32'h0000_5555, 1, 1'b1);

    mt(3'd4, 32'h1234_5678);
    check("mthi_busy", 64'(busy), 64'h0);
    mt(3'd5, 32'h9ABC_DEF0);
    check("mtlo_busy", 64'(busy), 64'h0);
    check("mt_hi", 64'(hi), 64'h1234_5678);
    check("mt_lo", 64'(lo), 64'h9ABC_DEF0);

    // Illegal op is ignored.
    start = 1'b1; op = 3'd6; rs_val = 32'hDEAD_BEEF;
    @(negedge Clk);
    start = 1'b0;
    check("illegal_busy", 64'(busy), 64'h0);
    check("illegal_hi", 64'(hi), 64'h1234_5678);

    // Abort mid-run with an ignored second start.
    mt(3'd4, 32'h1111_2222);
    mt(3'd5, 32'h3333_4444);
    start = 1'b1; op = 3'd0; rs_val = 32'hFFFF_FFFD; rt_val = 32'd5;
    @(negedge Clk);
    start = 1'b0;
    seen = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      start = (e == 5); op = 3'd2; rs_val = 32'd9; rt_val = 32'd3;
      abort = (e == 10);
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_no_done", 64'(seen), 64'h0);
    check("abort_hi", 64'(hi), 64'h1111_2222);
    check("abort_lo", 64'(lo), 64'h3333_4444);

    // Reset mid-run clears everything immediately.
    start = 1'b1; op = 3'd1; rs_val = 32'h0001_0003; rt_val = 32'h0000_0007;
    @(negedge Clk);
    start = 1'b0;
    repeat (10) @(negedge Clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_state", 64'(state_out), 64'h0);
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);
    check("rst_mid_done", 64'({done, div_by_zero}), 64'h0);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);

    // Narrow instance: MULT -3*5 at WIDTH=8.
    s8_start = 1'b1; s8_op = 3'd0; s8_rs = 8'hFD; s8_rt = 8'h05;
    @(negedge Clk);
    s8_start = 1'b0; s8_rs = 8'h5A; s8_rt = 8'hA5;
    k = 0;
    while (!s8_done && k < 30) begin @(negedge Clk); k++; end
    check("w8_latency", 64'(s8_done ? k : -1), 64'd9);
    check("w8_hi", 64'(s8_hi), 64'hFF);
    check("w8_lo", 64'(s8_lo), 64'hF1);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 3) == 0);
      op     = 3'($urandom_range(0, 7));
      rs_val = pick();
      rt_val = pick();
      abort  = ($urandom_range(0, 80) == 0);
      @(negedge Clk);
    end
    start = 1'b0; abort = 1'b0;
    repeat (40) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
